s1_detector_jogada: RTL
=======================

S1_DETECTOR_JOGADA -- requirements
Module: s1_detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000; number of consecutive stable cycles required to accept a press or release; legal range >= 2.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 botoes  input  4  raw, asynchronous, active-high push-button levels.
REQ-005 habilita  input  1  permits acceptance of a new press; driven high by the control unit while it waits for a player move.
REQ-006 jogada  output  1  one-cycle pulse marking an accepted press; this is the control unit's jogada input.
REQ-007 botoes_reg  output  4  pattern of the last accepted press; held until the next accepted press.
REQ-008 multiplo  output  1  high when the last accepted press had more than one button set; held with botoes_reg.
REQ-009 db_estado  output  3  current FSM state encoding, for debug.

Function
REQ-010 botoes shall pass through a 2-flop synchronizer; all logic below uses the synchronized value s.
REQ-011 The FSM shall have five states, encoded as OCIOSO=0, FILTRANDO=1, CONFIRMADO=2, AGUARDA_SOLTAR=3 and FILTRA_SOLTAR=4; db_estado shall equal the encoding.
REQ-012 OCIOSO: if habilita=1 and s!=0, capture s into amostra, clear the counter, and go to FILTRANDO; otherwise stay.
REQ-013 FILTRANDO transitions, in priority order:
- habilita=0 -> OCIOSO.
- s=0 -> OCIOSO.
- s!=amostra -> stay, recapture amostra=s, clear the counter.
- counter==DEBOUNCE_CYCLES-1 -> CONFIRMADO.
- otherwise increment the counter.
REQ-014 CONFIRMADO lasts exactly one cycle and then goes to AGUARDA_SOLTAR.
- jogada=1 in this state only (Moore output).
- On exit: botoes_reg<=amostra; multiplo<=(popcount(amostra)>1).
REQ-015 AGUARDA_SOLTAR: s=0 -> clear the counter and go to FILTRA_SOLTAR; otherwise stay.
- Pattern changes while held (e.g. a second button added) shall not generate a new jogada.
REQ-016 FILTRA_SOLTAR: s!=0 -> AGUARDA_SOLTAR; counter==DEBOUNCE_CYCLES-1 -> OCIOSO; otherwise increment the counter.
REQ-017 Release filtering shall complete regardless of habilita; habilita affects only the OCIOSO and FILTRANDO states.
REQ-018 The counter width shall be clog2(DEBOUNCE_CYCLES); the counter shall never wrap.
REQ-019 Latency: a raw press held stable produces jogada high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it.
- 2 edges: synchronizer.
- 1 edge: OCIOSO->FILTRANDO.
- DEBOUNCE_CYCLES edges: filter count.
REQ-020 At most one jogada pulse shall be produced per press-release cycle; two pulses shall be separated by at least 2*DEBOUNCE_CYCLES+2 cycles.
REQ-021 botoes_reg and multiplo shall change only on exit from CONFIRMADO or on reset.

Reset
REQ-022 On reset=1 at a rising edge, the block shall enter OCIOSO and clear the synchronizer flops, amostra, the counter, botoes_reg, multiplo and jogada, from any state, including mid-filter.
REQ-023 After reset, db_estado shall read 0.
REQ-024 A button already held when reset deasserts shall be treated as a new press (OCIOSO sees s!=0).

Verification (DEBOUNCE_CYCLES=4)
REQ-025 habilita=1; botoes=0010 held for 20 cycles, then released -> exactly one jogada pulse, 7 edges after the press is first sampled; botoes_reg=0010; multiplo=0.
REQ-026 habilita=1; botoes toggles 0001/0000 every 2 cycles for 20 cycles (bounce), then holds 0001 -> no jogada during bouncing; one jogada 7 edges after the hold starts.
REQ-027 habilita=1; botoes=0101 held -> jogada pulse; botoes_reg=0101; multiplo=1.
REQ-028 habilita=0 with botoes=1000 held 30 cycles -> no jogada; raise habilita with the button still held -> jogada 5 edges later (OCIOSO->FILTRANDO takes 1 edge, then 4 filter edges).
REQ-029 Press 0100 accepted, then 0110 while held, then release -> only one jogada; botoes_reg stays 0100.
REQ-030 reset pulsed while in FILTRANDO with the counter at 2 -> db_estado=0 and all outputs 0 on the next cycle; no jogada until a full new filter completes.

Source files
------------

// File: rtl/s1_detector_jogada.sv
// Debounced play detector: synchronizes raw buttons, filters press and
// release, and emits a single jogada pulse per accepted press.
module s1_detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic       jogada,
  output logic [3:0] botoes_reg,
  output logic       multiplo,
  output logic [2:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    FILTRANDO      = 3'd1,
    CONFIRMADO     = 3'd2,
    AGUARDA_SOLTAR = 3'd3,
    FILTRA_SOLTAR  = 3'd4
  } estado_t;

  estado_t       estado;
  logic [3:0]    sync1;
  logic [3:0]    s;
  logic [3:0]    amostra;
  logic [CW-1:0] contador;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= botoes;
      s     <= sync1;
    end
  end

  // jogada is set on the edge entering CONFIRMADO, so it is high
  // exactly while the FSM sits in that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      amostra    <= '0;
      contador   <= '0;
      jogada     <= 1'b0;
      botoes_reg <= '0;
      multiplo   <= 1'b0;
    end else begin
      jogada <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (habilita && s != '0) begin
            amostra  <= s;
            contador <= '0;
            estado   <= FILTRANDO;
          end
        end
        FILTRANDO: begin
          if (!habilita || s == '0) begin
            estado <= OCIOSO;
          end else if (s != amostra) begin
            amostra  <= s;
            contador <= '0;
          end else if (contador == CMAX) begin
            estado <= CONFIRMADO;
            jogada <= 1'b1;
          end else begin
            contador <= contador + CW'(1);
          end
        end
        CONFIRMADO: begin
          estado     <= AGUARDA_SOLTAR;
          botoes_reg <= amostra;
          multiplo   <= ($countones(amostra) > 1);
        end
        AGUARDA_SOLTAR: begin
          if (s == '0) begin
            contador <= '0;
            estado   <= FILTRA_SOLTAR;
          end
        end
        FILTRA_SOLTAR: begin
          if (s != '0) begin
            estado <= AGUARDA_SOLTAR;
          end else if (contador == CMAX) begin
            estado <= OCIOSO;
          end else begin
            contador <= contador + CW'(1);
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign db_estado = estado;

endmodule
